// File: rtl/pe_array_sequencer_if.sv
// Host/array bundle for the PE-array sequencer.
// The slave modport is the sequencer side. The master modport is the environment side,
// which is the host that pushes instructions plus the PE array that answers handshakes.
interface pe_array_sequencer_if #(
    parameter int command_width = 4,
    parameter int REP_WIDTH     = 4
);
    logic                     push_valid;
    logic [command_width-1:0] push_cmd;
    logic [REP_WIDTH-1:0]     push_rep;
    logic                     push_ready;
    logic                     array_ready;
    logic                     array_ack;
    logic [command_width-1:0] command_to_execute;

    modport master (
        output push_valid, push_cmd, push_rep, array_ready,
        input  push_ready, array_ack, command_to_execute
    );

    modport slave (
        input  push_valid, push_cmd, push_rep, array_ready,
        output push_ready, array_ack, command_to_execute
    );
endinterface

// File: rtl/pe_array_sequencer.sv
// PE-array instruction sequencer.
// Instructions are queued in a FIFO and drained while go is high. Each instruction
// is issued as (rep + 1) four-phase ack/ready handshakes. A stalled phase times out
// into a sticky ERROR state, which flushes the queue.
module pe_array_sequencer #(
    parameter int command_width = 4,
    parameter int REP_WIDTH     = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic                        CLK,
    input  logic                        RST,
    pe_array_sequencer_if.slave         bus,
    input  logic                        go,
    input  logic                        clear_err,
    output logic                        idle,
    output logic                        err,
    output logic [15:0]                 issued_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ASSERT = 3'd2;
    localparam logic [2:0] S_DROP   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    // Codes 8 and above are not executable by the array and are dropped in LOAD.
    localparam logic [command_width:0] EXEC_LIMIT = (command_width + 1)'(8);

    typedef struct packed {
        logic [command_width-1:0] cmd;
        logic [REP_WIDTH-1:0]     rep;
    } entry_t;

    entry_t                   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [2:0]               state_q, state_d;
    logic [REP_WIDTH-1:0]     rep_cnt_q, rep_cnt_d;
    logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [command_width-1:0] cmd_q, cmd_d;
    logic                     ack_q, ack_d;
    logic [15:0]              issued_q, issued_d;

    logic   push_fire;
    logic   pop;
    entry_t head;
    entry_t push_entry;

    assign head              = mem_q[rd_ptr_q];
    assign push_entry        = '{cmd: bus.push_cmd, rep: bus.push_rep};
    assign bus.push_ready    = (count_q != CNT_W'(FIFO_DEPTH)) && (state_q != S_ERROR);
    assign push_fire         = bus.push_valid && bus.push_ready;
    assign bus.array_ack     = ack_q;
    assign bus.command_to_execute = cmd_q;
    assign idle              = (state_q == S_IDLE);
    assign err               = (state_q == S_ERROR);
    assign issued_count      = issued_q;

    // Next-state logic for the FSM, the repeat and wait counters, and the queue pointers.
    always_comb begin
        // NOTE: every output of this block gets a default first, so a path that does not
        // assign it still cannot infer a latch.
        state_d    = state_q;
        rep_cnt_d  = rep_cnt_q;
        cmd_d      = cmd_q;
        issued_d   = issued_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go && count_q != '0) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop       = 1'b1;
                rep_cnt_d = head.rep;
                if ({1'b0, head.cmd} < EXEC_LIMIT) begin
                    cmd_d   = head.cmd;
                    state_d = S_ASSERT;
                end else if (go && count_q > CNT_W'(1)) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ASSERT: begin
                if (!bus.array_ready)                     state_d = S_DROP;
                else if (wait_cnt_q == WAIT_W'(TIMEOUT))  state_d = S_ERROR;
            end
            S_DROP: begin
                if (bus.array_ready) begin
                    if (issued_q != 16'hFFFF) issued_d = issued_q + 1'b1;
                    if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - 1'b1;
                        state_d   = S_ASSERT;
                    end else if (go && count_q != '0) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                if (clear_err) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The wait counter restarts on every entry into a handshake phase.
        if ((state_d == S_ASSERT || state_d == S_DROP) && state_d == state_q)
            wait_cnt_d = wait_cnt_q + 1'b1;
        else
            wait_cnt_d = '0;

        // The ack output is registered from the next state, so it is high exactly while the FSM is in ASSERT.
        ack_d = (state_d == S_ASSERT);

        wr_ptr_d = push_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop       ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_fire, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A timeout discards everything still queued, including an entry pushed on the same edge.
        if (state_d == S_ERROR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rep_cnt_q  <= '0;
            wait_cnt_q <= '0;
            cmd_q      <= '0;
            ack_q      <= 1'b0;
            issued_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rep_cnt_q  <= rep_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            cmd_q      <= cmd_d;
            ack_q      <= ack_d;
            issued_q   <= issued_d;
        end
    end

    // Instruction storage written on accepted pushes.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array has no reset. An entry is only read after it has been
        // written, because occupancy is tracked by the reset pointers and count.
        if (push_fire) mem_q[wr_ptr_q] <= push_entry;
    end
endmodule
